// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the multiply/divide unit.
//   - MDU operation codes carried on HILOCtrl
//   - FSM state encoding
//   - default busy latencies for multiply and divide
//   - helper that identifies the codes which launch a multi-cycle operation
package mult_div_unit_pkg;

    typedef enum logic [3:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MFHI  = 4'd5,
        MDU_MFLO  = 4'd6,
        MDU_MTHI  = 4'd7,
        MDU_MTLO  = 4'd8
    } mdu_op_e;

    typedef enum logic {
        MDU_IDLE = 1'b0,
        MDU_RUN  = 1'b1
    } mdu_state_e;

    localparam int MDU_MULT_CYCLES_DEF = 5;
    localparam int MDU_DIV_CYCLES_DEF  = 10;

    function automatic logic is_arith_op(input logic [3:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) ||
               (op == MDU_DIV)  || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mult_div_unit_arith.sv
// mdu_arith: combinational arithmetic core of the multiply/divide unit.
// Produces the 64-bit {hi, lo} result for mult/multu/div/divu.
//   op     in  4  : operation code (mdu_op_e values)
//   d1     in  32 : rs operand (dividend / multiplicand)
//   d2     in  32 : rt operand (divisor / multiplier)
//   result out 64 : {hi, lo}; zero for non-arithmetic codes
// Divide corner cases: 0x80000000 / -1 gives lo=0x80000000, hi=0;
// divide by zero gives hi=d1, lo=0xFFFFFFFF (never X).
module mdu_arith
    import mult_div_unit_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] d1,
    input  logic [31:0] d2,
    output logic [63:0] result
);

    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic signed [31:0] sd1;
    logic signed [31:0] sdiv;
    logic signed [31:0] quo_s;
    logic signed [31:0] rem_s;
    logic        [31:0] udiv;
    logic        [31:0] quo_u;
    logic        [31:0] rem_u;
    logic               d2_zero;
    logic               div_ovf;

    assign prod_s = $signed({{32{d1[31]}}, d1}) * $signed({{32{d2[31]}}, d2});
    assign prod_u = {32'd0, d1} * {32'd0, d2};

    assign d2_zero = (d2 == 32'd0);
    assign div_ovf = (d1 == 32'h8000_0000) && (d2 == 32'hFFFF_FFFF);

    // The dividers never see a zero divisor or the overflowing pair; those
    // cases are substituted below, so the raw quotient is only used when valid.
    assign sd1   = $signed(d1);
    assign sdiv  = (d2_zero || div_ovf) ? 32'sd1 : $signed(d2);
    assign quo_s = sd1 / sdiv;
    assign rem_s = sd1 % sdiv;

    assign udiv  = d2_zero ? 32'd1 : d2;
    assign quo_u = d1 / udiv;
    assign rem_u = d1 % udiv;

    always_comb begin
        result = 64'd0;
        case (op)
            MDU_MULT:  result = prod_s;
            MDU_MULTU: result = prod_u;
            MDU_DIV: begin
                if (d2_zero)      result = {d1, 32'hFFFF_FFFF};
                else if (div_ovf) result = {32'd0, 32'h8000_0000};
                else              result = {rem_s, quo_s};
            end
            MDU_DIVU: begin
                if (d2_zero) result = {d1, 32'hFFFF_FFFF};
                else         result = {rem_u, quo_u};
            end
            default: result = 64'd0;
        endcase
    end

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle multiply/divide unit with architectural HI/LO.
// Optional feature macro: MDU_DIV_ZERO_GUARD_EN -- when defined, div/divu by
// zero is dropped (no busy period, HI/LO unchanged).
//   clk      in  1  : clock
//   rst_n    in  1  : asynchronous active-low reset
//   Start    in  1  : launch mult/multu/div/divu (with matching HILOCtrl)
//   HILOCtrl in  4  : operation code
//   D1       in  32 : rs operand
//   D2       in  32 : rt operand
//   Req      in  1  : exception flush; suppresses a new launch / MTHI / MTLO
//   Busy     out 1  : operation in flight
//   HI, LO   out 32 : architectural HI/LO registers
//   Out      out 32 : HI for MFHI, LO for MFLO, else 0 (combinational)
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int MULT_CYCLES = MDU_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Start,
    input  logic [3:0]  HILOCtrl,
    input  logic [31:0] D1,
    input  logic [31:0] D2,
    input  logic        Req,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] Out
);

    mdu_state_e  state, state_next;
    logic [3:0]  cnt, cnt_next;
    logic [31:0] tmp_hi, tmp_lo;
    logic [63:0] arith_result;
    logic        is_div;
    logic        launch_block;
    logic        launch, commit, write_hi, write_lo;

    mdu_arith u_arith (
        .op     (HILOCtrl),
        .d1     (D1),
        .d2     (D2),
        .result (arith_result)
    );

    assign is_div = (HILOCtrl == MDU_DIV) || (HILOCtrl == MDU_DIVU);

`ifdef MDU_DIV_ZERO_GUARD_EN
    assign launch_block = is_div && (D2 == 32'd0);
`else
    assign launch_block = 1'b0;
`endif

    // Once launched, an operation has passed the commit point: Req no longer
    // matters in RUN, and new requests are ignored until it completes.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        launch     = 1'b0;
        commit     = 1'b0;
        write_hi   = 1'b0;
        write_lo   = 1'b0;
        case (state)
            MDU_IDLE: begin
                if (!Req) begin
                    if (Start && is_arith_op(HILOCtrl) && !launch_block) begin
                        launch     = 1'b1;
                        state_next = MDU_RUN;
                        cnt_next   = is_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
                    end
                    write_hi = (HILOCtrl == MDU_MTHI);
                    write_lo = (HILOCtrl == MDU_MTLO);
                end
            end
            MDU_RUN: begin
                if (cnt == 4'd1) begin
                    commit     = 1'b1;
                    state_next = MDU_IDLE;
                    cnt_next   = 4'd0;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            default: state_next = MDU_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= MDU_IDLE;
            cnt    <= 4'd0;
            tmp_hi <= 32'd0;
            tmp_lo <= 32'd0;
            HI     <= 32'd0;
            LO     <= 32'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (launch) begin
                tmp_hi <= arith_result[63:32];
                tmp_lo <= arith_result[31:0];
            end
            if (commit) begin
                HI <= tmp_hi;
                LO <= tmp_lo;
            end else begin
                if (write_hi) HI <= D1;
                if (write_lo) LO <= D1;
            end
        end
    end

    assign Busy = (state == MDU_RUN);

    always_comb begin
        Out = 32'd0;
        if (HILOCtrl == MDU_MFHI)      Out = HI;
        else if (HILOCtrl == MDU_MFLO) Out = LO;
    end

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;
    import mult_div_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        Start = 1'b0;
    logic [3:0]  HILOCtrl = 4'd0;
    logic [31:0] D1 = 32'd0;
    logic [31:0] D2 = 32'd0;
    logic        Req = 1'b0;
    logic        Busy;
    logic [31:0] HI, LO, Out;

    always #5 clk = ~clk;

    mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .rst_n(rst_n), .Start(Start), .HILOCtrl(HILOCtrl),
        .D1(D1), .D2(D2), .Req(Req), .Busy(Busy), .HI(HI), .LO(LO), .Out(Out)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Launch/MTx while Busy must never be presented by this bench.
    always @(posedge clk) begin
        if (rst_n && Busy && Start) begin
            errors++;
            $display("FAIL protocol: Start presented while Busy (op %0d)", HILOCtrl);
        end
    end

    // Architectural reference: what HI/LO become and how long the unit is busy.
    function automatic void ref_op(input logic [3:0] op, input logic [31:0] d1,
                                   input logic [31:0] d2, output logic [31:0] hi,
                                   output logic [31:0] lo, output int cyc);
        longint      a, b, q, r;
        logic [63:0] p;
        hi = m_hi; lo = m_lo; cyc = 0;
        if (op == MDU_MULT) begin
            a = $signed(d1); b = $signed(d2); p = 64'(a * b);
            hi = p[63:32]; lo = p[31:0]; cyc = 5;
        end else if (op == MDU_MULTU) begin
            p = {32'd0, d1} * {32'd0, d2};
            hi = p[63:32]; lo = p[31:0]; cyc = 5;
        end else if (op == MDU_DIV || op == MDU_DIVU) begin
            if (d2 == 32'd0) begin
`ifdef MDU_DIV_ZERO_GUARD_EN
                cyc = 0;
`else
                hi = d1; lo = 32'hFFFF_FFFF; cyc = 10;
`endif
            end else begin
                if (op == MDU_DIV) begin a = $signed(d1); b = $signed(d2); end
                else begin a = longint'({32'd0, d1}); b = longint'({32'd0, d2}); end
                q = a / b; r = a % b;
                hi = r[31:0]; lo = q[31:0]; cyc = 10;
            end
        end else if (op == MDU_MTHI) begin
            hi = d1;
        end else if (op == MDU_MTLO) begin
            lo = d1;
        end
    endfunction

    // Present one request for one cycle, then count Busy cycles (bounded).
    // req_at > 0 raises Req during that busy cycle.
    task automatic run_op(input logic [3:0] op, input logic [31:0] d1, input logic [31:0] d2,
                          input int req_at, output int cyc);
        @(negedge clk);
        Start = is_arith_op(op); HILOCtrl = op; D1 = d1; D2 = d2;
        @(negedge clk);
        Start = 1'b0; HILOCtrl = MDU_NONE;
        cyc = 0;
        while (Busy && cyc < 40) begin
            cyc++;
            Req = (cyc == req_at);
            @(negedge clk);
        end
        Req = 1'b0;
        if (cyc >= 40) begin
            errors++;
            $display("FAIL busy_timeout: Busy still high after %0d cycles", cyc);
        end
    endtask

    task automatic read_out(input string name);
        @(negedge clk);
        HILOCtrl = MDU_MFHI; #1;
        check({name, "_mfhi"}, Out, m_hi);
        HILOCtrl = MDU_MFLO; #1;
        check({name, "_mflo"}, Out, m_lo);
        HILOCtrl = MDU_NONE;
    endtask

    initial begin
        int          cyc;
        int          ecyc;
        logic [31:0] ehi, elo;
        logic [3:0]  op;
        logic [31:0] r1, r2;
        logic [3:0]  rand_ops[6];

        vecs[0] = '{MDU_MULT,  32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA, 5};
        vecs[1] = '{MDU_MULTU, 32'hFFFF_FFFE, 32'd3,         32'h0000_0002, 32'hFFFF_FFFA, 5};
        vecs[2] = '{MDU_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
        vecs[3] = '{MDU_DIVU,  32'd7,         32'd2,         32'd1,         32'd3,         10};
        vecs[4] = '{MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 10};
        rand_ops = '{MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI, MDU_MTLO};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, Busy}, 32'd0);
        check("rst_hi", HI, 32'd0);
        check("rst_lo", LO, 32'd0);
        check("rst_out", Out, 32'd0);
        rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < 5; i++) begin
            run_op(vecs[i].op, vecs[i].d1, vecs[i].d2, 0, cyc);
            check($sformatf("vec%0d_cycles", i), 32'(cyc), 32'(vecs[i].cyc));
            check($sformatf("vec%0d_hi", i), HI, vecs[i].hi);
            check($sformatf("vec%0d_lo", i), LO, vecs[i].lo);
            m_hi = vecs[i].hi; m_lo = vecs[i].lo;
        end
        read_out("table");

        // Divide by zero under the active build configuration
        run_op(MDU_DIV, 32'd5, 32'd0, 0, cyc);
`ifdef MDU_DIV_ZERO_GUARD_EN
        check("div0_cycles", 32'(cyc), 32'd0);
`else
        check("div0_cycles", 32'(cyc), 32'd10);
        m_hi = 32'd5; m_lo = 32'hFFFF_FFFF;
`endif
        check("div0_hi", HI, m_hi);
        check("div0_lo", LO, m_lo);

        // No-op code with Start
        run_op(4'd12, 32'd9, 32'd9, 0, cyc);
        check("noop_cycles", 32'(cyc), 32'd0);
        check("noop_hi", HI, m_hi);
        HILOCtrl = 4'd12; #1;
        check("noop_out", Out, 32'd0);
        HILOCtrl = MDU_NONE;

        // Start with Req: suppressed
        @(negedge clk);
        Start = 1'b1; HILOCtrl = MDU_MULT; D1 = 32'd3; D2 = 32'd4; Req = 1'b1;
        @(negedge clk);
        Start = 1'b0; HILOCtrl = MDU_NONE; Req = 1'b0;
        check("req_start_busy", {31'd0, Busy}, 32'd0);
        @(negedge clk);
        check("req_start_hi", HI, m_hi);
        check("req_start_lo", LO, m_lo);

        // MTLO with Req: suppressed
        @(negedge clk);
        HILOCtrl = MDU_MTLO; D1 = 32'h1234; Req = 1'b1;
        @(negedge clk);
        HILOCtrl = MDU_NONE; Req = 1'b0;
        check("req_mtlo_lo", LO, m_lo);

        // Req during RUN does not abort
        run_op(MDU_MULT, 32'd1000, 32'hFFFF_FFF0, 2, cyc);
        ref_op(MDU_MULT, 32'd1000, 32'hFFFF_FFF0, ehi, elo, ecyc);
        check("req_run_cycles", 32'(cyc), 32'd5);
        check("req_run_hi", HI, ehi);
        check("req_run_lo", LO, elo);
        m_hi = ehi; m_lo = elo;

        // Randomized operations against the reference model
        for (int i = 0; i < 40; i++) begin
            op = rand_ops[$urandom_range(0, 5)];
            r1 = $urandom;
            r2 = $urandom;
            case ($urandom_range(0, 7))
                0: r2 = 32'd0;
                1: r2 = 32'(int'($urandom_range(0, 6)) - 3);
                2: begin r1 = 32'h8000_0000; r2 = 32'hFFFF_FFFF; end
                default: ;
            endcase
            ref_op(op, r1, r2, ehi, elo, ecyc);
            run_op(op, r1, r2, 0, cyc);
            check($sformatf("rnd%0d_op%0d_cycles", i, op), 32'(cyc), 32'(ecyc));
            check($sformatf("rnd%0d_op%0d_hi", i, op), HI, ehi);
            check($sformatf("rnd%0d_op%0d_lo", i, op), LO, elo);
            m_hi = ehi; m_lo = elo;
        end
        read_out("random");

        // Asynchronous reset mid-divide
        run_op(MDU_MTHI, 32'h5555_0001, 32'd0, 0, cyc);
        run_op(MDU_MTLO, 32'h5555_0002, 32'd0, 0, cyc);
        @(negedge clk);
        Start = 1'b1; HILOCtrl = MDU_DIV; D1 = 32'd100; D2 = 32'd7;
        @(negedge clk);
        Start = 1'b0; HILOCtrl = MDU_NONE;
        repeat (2) @(negedge clk);
        check("pre_rst_busy", {31'd0, Busy}, 32'd1);
        #2 rst_n = 1'b0; #1;
        check("async_rst_busy", {31'd0, Busy}, 32'd0);
        check("async_rst_hi", HI, 32'd0);
        check("async_rst_lo", LO, 32'd0);
        check("async_rst_out", Out, 32'd0);
        m_hi = 32'd0; m_lo = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        HILOCtrl = MDU_MTHI; D1 = 32'hABCD;
        @(negedge clk);
        HILOCtrl = MDU_MFHI; #1;
        check("post_rst_mfhi", Out, 32'hABCD);
        check("post_rst_lo", LO, 32'd0);
        HILOCtrl = MDU_NONE;
        repeat (2) @(negedge clk);
        check("post_rst_idle", {31'd0, Busy}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
